asp_op_executor: RTL and testbench

//   Executes the 2-bit opcode issued by the control unit. TXE moves one burst host->network, XOR-encrypted.
//   RXA moves one burst network->host, XOR-decrypted. LOG bumps the network-alert counter.

---
 rtl/asp_pkg.sv | 23 ++
 rtl/asp_stall_timer.sv | 30 +++
 rtl/asp_op_executor.sv | 178 +++++++++++++++++
 tb/tb_asp_op_executor.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/asp_pkg.sv
// asp_pkg: opcode constants shared with the control unit and the executor state encoding.
// Also holds the saturating 16-bit increment used by the alert counter.
package asp_pkg;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_TXE = 2'b01;
    localparam logic [1:0] OP_RXA = 2'b10;
    localparam logic [1:0] OP_LOG = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX,
        ST_RX,
        ST_LOG,
        ST_CHK,
        ST_DONE
    } exec_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/asp_stall_timer.sv
// asp_stall_timer: counts consecutive stall cycles; expired flags the TIMEOUT_CYC-th one.
// clear has priority over enable and returns the count to zero.
module asp_stall_timer #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TW-1:0] count;

    // count holds the number of stall cycles already seen, so the current one is count+1
    assign expired = enable && (count == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/asp_op_executor.sv
// asp_op_executor: runs TXE/RXA bursts with XOR pass-through and LOG alert counting.
// Define ASP_CHECKSUM_EN to append a running-XOR checksum word to every burst.
module asp_op_executor
    import asp_pkg::*;
#(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       BURST_LEN   = 4,
    parameter logic [DATA_W-1:0] KEY         = 32'hA5A5_5A5A,
    parameter int unsigned       TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        opcode_in,
    input  logic [DATA_W-1:0] host_data_in,
    input  logic              host_valid_in,
    output logic              host_ready_out,
    output logic [DATA_W-1:0] net_tx_data_out,
    output logic              net_tx_valid_out,
    input  logic              net_tx_ready_in,
    input  logic [DATA_W-1:0] net_rx_data_in,
    input  logic              net_rx_valid_in,
    output logic              net_rx_ready_out,
    output logic [DATA_W-1:0] host_rx_data_out,
    output logic              host_rx_valid_out,
    input  logic              host_rx_ready_in,
    output logic [15:0]       log_count_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              err_out
);

    localparam int unsigned CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

`ifdef ASP_CHECKSUM_EN
    localparam exec_state_t BURST_END = ST_CHK;
`else
    localparam exec_state_t BURST_END = ST_DONE;
`endif

    exec_state_t   state;
    logic [CW-1:0] wcnt;
    logic [15:0]   log_count;
    logic          tx_xfer;
    logic          rx_xfer;
    logic          xfer;
    logic          active;
    logic          last_word;
    logic          stall_clear;
    logic          stall_en;
    logic          expired;

`ifdef ASP_CHECKSUM_EN
    logic              chk_rx;
    logic [DATA_W-1:0] sum;
    logic              chk_xfer;
    logic              chk_ok;
`endif

    always_comb begin
        tx_xfer   = (state == ST_TX) && host_valid_in && net_tx_ready_in;
        rx_xfer   = (state == ST_RX) && net_rx_valid_in && host_rx_ready_in;
        last_word = (wcnt == CW'(BURST_LEN - 1));
        active    = (state == ST_TX) || (state == ST_RX);
        xfer      = tx_xfer || rx_xfer;
`ifdef ASP_CHECKSUM_EN
        chk_xfer  = (state == ST_CHK) && (chk_rx ? net_rx_valid_in : net_tx_ready_in);
        chk_ok    = !chk_rx || ((net_rx_data_in ^ KEY) == sum);
        active    = active || (state == ST_CHK);
        xfer      = xfer || chk_xfer;
`endif
    end

    // Idle states hold the timer clear, so every TX/RX entry starts from zero
    assign stall_clear = !active || xfer;
    assign stall_en    = active && !xfer;

    asp_stall_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_stall_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (stall_clear),
        .enable (stall_en),
        .expired(expired)
    );

    always_comb begin
        host_ready_out    = (state == ST_TX) && net_tx_ready_in;
        net_tx_valid_out  = (state == ST_TX) && host_valid_in;
        net_tx_data_out   = (state == ST_TX) ? (host_data_in ^ KEY) : '0;
        net_rx_ready_out  = (state == ST_RX) && host_rx_ready_in;
        host_rx_valid_out = (state == ST_RX) && net_rx_valid_in;
        host_rx_data_out  = (state == ST_RX) ? (net_rx_data_in ^ KEY) : '0;
        err_out           = expired;
`ifdef ASP_CHECKSUM_EN
        if (state == ST_CHK) begin
            if (chk_rx) begin
                net_rx_ready_out = 1'b1;
            end else begin
                net_tx_valid_out = 1'b1;
                net_tx_data_out  = sum ^ KEY;
            end
        end
        err_out = expired || (chk_xfer && !chk_ok);
`endif
    end

    assign done_out      = (state == ST_DONE);
    assign busy_out      = (state != ST_IDLE);
    assign log_count_out = log_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            wcnt      <= '0;
            log_count <= '0;
`ifdef ASP_CHECKSUM_EN
            chk_rx    <= 1'b0;
            sum       <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    wcnt <= '0;
                    case (opcode_in)
                        OP_TXE: begin
                            state <= ST_TX;
`ifdef ASP_CHECKSUM_EN
                            chk_rx <= 1'b0;
                            sum    <= '0;
`endif
                        end
                        OP_RXA: begin
                            state <= ST_RX;
`ifdef ASP_CHECKSUM_EN
                            chk_rx <= 1'b1;
                            sum    <= '0;
`endif
                        end
                        OP_LOG:  state <= ST_LOG;
                        default: state <= ST_IDLE;
                    endcase
                end
                ST_TX, ST_RX: begin
                    if (expired) begin
                        state <= ST_IDLE;
                    end else if (xfer) begin
`ifdef ASP_CHECKSUM_EN
                        sum <= sum ^ (tx_xfer ? host_data_in : (net_rx_data_in ^ KEY));
`endif
                        if (last_word) begin
                            wcnt  <= '0;
                            state <= BURST_END;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
`ifdef ASP_CHECKSUM_EN
                ST_CHK: begin
                    if (expired) begin
                        state <= ST_IDLE;
                    end else if (chk_xfer) begin
                        state <= chk_ok ? ST_DONE : ST_IDLE;
                    end
                end
`endif
                ST_LOG: begin
                    log_count <= sat_inc16(log_count);
                    state     <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_asp_op_executor.sv
// tb_asp_op_executor: directed plus randomized bursts checked against a transaction-level model.
// Build with ASP_CHECKSUM_EN defined to also cover the checksum word.
module tb_asp_op_executor;
    import asp_pkg::*;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned BURST_LEN   = 4;
    localparam int unsigned TIMEOUT_CYC = 20;
    localparam logic [31:0] KEY         = 32'hA5A5_5A5A;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  opcode;
    logic [31:0] host_data;
    logic        host_valid;
    logic        host_ready;
    logic [31:0] net_tx_data;
    logic        net_tx_valid;
    logic        net_tx_ready;
    logic [31:0] net_rx_data;
    logic        net_rx_valid;
    logic        net_rx_ready;
    logic [31:0] host_rx_data;
    logic        host_rx_valid;
    logic        host_rx_ready;
    logic [15:0] log_count;
    logic        busy;
    logic        done;
    logic        err;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_log  = '0;
    logic [31:0] wbuf [BURST_LEN];
`ifdef ASP_CHECKSUM_EN
    logic        corrupt_chk = 1'b0;
`endif

    always #5 clk = ~clk;

    asp_op_executor #(
        .DATA_W(DATA_W),
        .BURST_LEN(BURST_LEN),
        .KEY(KEY),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .opcode_in(opcode),
        .host_data_in(host_data),
        .host_valid_in(host_valid),
        .host_ready_out(host_ready),
        .net_tx_data_out(net_tx_data),
        .net_tx_valid_out(net_tx_valid),
        .net_tx_ready_in(net_tx_ready),
        .net_rx_data_in(net_rx_data),
        .net_rx_valid_in(net_rx_valid),
        .net_rx_ready_out(net_rx_ready),
        .host_rx_data_out(host_rx_data),
        .host_rx_valid_out(host_rx_valid),
        .host_rx_ready_in(host_rx_ready),
        .log_count_out(log_count),
        .busy_out(busy),
        .done_out(done),
        .err_out(err)
    );

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        opcode        = OP_NOP;
        host_data     = '0;
        host_valid    = 1'b0;
        net_tx_ready  = 1'b0;
        net_rx_data   = '0;
        net_rx_valid  = 1'b0;
        host_rx_ready = 1'b0;
    endtask

    task automatic expect_done();
        @(negedge clk);
        idle_inputs();
        #1;
        check1("done_pulse", done, 1'b1);
        check1("done_busy", busy, 1'b1);
        check1("done_err", err, 1'b0);
        @(negedge clk);
        #1;
        check1("done_once", done, 1'b0);
        check1("idle_busy", busy, 1'b0);
    endtask

    // One TXE burst of wbuf; each word must appear encrypted exactly once.
    task automatic run_txe(input logic rand_stall);
        int unsigned idx = 0;
        int unsigned cycles = 0;
        int unsigned streak = 0;
        logic v;
        logic r;
        logic [31:0] sum = '0;
        @(negedge clk);
        opcode = OP_TXE;
        while (idx < BURST_LEN && cycles < 200) begin
            @(negedge clk);
            opcode = OP_NOP;
            cycles++;
            v = rand_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            r = rand_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (streak >= 4) begin
                v = 1'b1;
                r = 1'b1;
            end
            host_valid   = v;
            net_tx_ready = r;
            host_data    = wbuf[idx];
            #1;
            check1("tx_valid", net_tx_valid, v);
            check1("tx_host_ready", host_ready, r);
            check1("tx_busy", busy, 1'b1);
            if (v) check32("tx_data", net_tx_data, wbuf[idx] ^ KEY);
            if (v && r) begin
                sum = sum ^ wbuf[idx];
                idx++;
                streak = 0;
            end else begin
                streak++;
            end
        end
        check1("tx_burst_complete", idx == BURST_LEN, 1'b1);
        if (!rand_stall) check32("tx_cycles", cycles, BURST_LEN);
`ifdef ASP_CHECKSUM_EN
        r = 1'b0;
        while (!r) begin
            @(negedge clk);
            host_valid   = 1'b0;
            r            = ($urandom_range(0, 1) != 0) || !rand_stall;
            net_tx_ready = r;
            #1;
            check1("tx_chk_valid", net_tx_valid, 1'b1);
            check32("tx_chk_data", net_tx_data, sum ^ KEY);
        end
`else
        check32("tx_sum_model", sum ^ sum, '0);
`endif
        expect_done();
    endtask

    // One RXA burst; mid_hold stalls the host for 3 cycles on word index 2.
    task automatic run_rxa(input logic rand_stall, input logic mid_hold);
        int unsigned idx = 0;
        int unsigned cycles = 0;
        int unsigned streak = 0;
        int unsigned hold = 0;
        logic v;
        logic r;
        logic [31:0] got [$];
        @(negedge clk);
        opcode = OP_RXA;
        while (idx < BURST_LEN && cycles < 200) begin
            @(negedge clk);
            opcode = OP_NOP;
            cycles++;
            v = rand_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            r = rand_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (streak >= 4) begin
                v = 1'b1;
                r = 1'b1;
            end
            if (mid_hold && idx == 2 && hold < 3) begin
                v = 1'b1;
                r = 1'b0;
                hold++;
            end
            net_rx_valid  = v;
            host_rx_ready = r;
            net_rx_data   = wbuf[idx] ^ KEY;
            #1;
            check1("rx_valid", host_rx_valid, v);
            check1("rx_net_ready", net_rx_ready, r);
            check1("rx_done_early", done, 1'b0);
            if (v) check32("rx_data", host_rx_data, wbuf[idx]);
            if (v && r) begin
                got.push_back(host_rx_data);
                idx++;
                streak = 0;
            end else begin
                streak++;
            end
        end
        check32("rx_word_count", got.size(), BURST_LEN);
`ifdef ASP_CHECKSUM_EN
        begin
            logic [31:0] sum = '0;
            foreach (wbuf[i]) sum = sum ^ wbuf[i];
            @(negedge clk);
            host_rx_ready = 1'b0;
            net_rx_valid  = 1'b1;
            net_rx_data   = corrupt_chk ? ((sum ^ 32'h1) ^ KEY) : (sum ^ KEY);
            #1;
            check1("rx_chk_ready", net_rx_ready, 1'b1);
            check1("rx_chk_not_fwd", host_rx_valid, 1'b0);
            check1("rx_chk_err", err, corrupt_chk);
            if (corrupt_chk) begin
                @(negedge clk);
                idle_inputs();
                #1;
                check1("rx_chk_bad_busy", busy, 1'b0);
                check1("rx_chk_bad_done", done, 1'b0);
                return;
            end
        end
`endif
        expect_done();
    endtask

    task automatic run_log();
        @(negedge clk);
        opcode = OP_LOG;
        @(negedge clk);
        opcode = OP_NOP;
        #1;
        check1("log_busy", busy, 1'b1);
        check1("log_done_early", done, 1'b0);
        @(negedge clk);
        #1;
        exp_log = (exp_log == 16'hFFFF) ? exp_log : exp_log + 16'd1;
        check32("log_count", {16'h0, log_count}, {16'h0, exp_log});
        check1("log_done", done, 1'b1);
        @(negedge clk);
        #1;
        check1("log_idle", busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        reset = 1'b1;
        #1;
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_err", err, 1'b0);
        check1("rst_tx_valid", net_tx_valid, 1'b0);
        check1("rst_rx_ready", net_rx_ready, 1'b0);
        check32("rst_log", {16'h0, log_count}, '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Test 1: TXE of 1..4, no back-pressure
        for (int i = 0; i < BURST_LEN; i++) wbuf[i] = 32'(i + 1);
        run_txe(1'b0);

        // Test 3: LOG x3, then saturation from FFFF
        for (int i = 0; i < 3; i++) run_log();
        check32("log_three", {16'h0, log_count}, 32'd3);
        @(negedge clk);
        force dut.log_count = 16'hFFFF;
        @(negedge clk);
        release dut.log_count;
        exp_log = 16'hFFFF;
        #1;
        check32("log_preload", {16'h0, log_count}, 32'h0000_FFFF);
        run_log();

        // Test 2: RXA with host stall mid-burst
        for (int i = 0; i < BURST_LEN; i++) wbuf[i] = $urandom;
        run_rxa(1'b0, 1'b1);

        // Test 4: TXE with no host data -> timeout
        @(negedge clk);
        opcode = OP_TXE;
        for (int c = 1; c <= TIMEOUT_CYC; c++) begin
            @(negedge clk);
            opcode       = OP_NOP;
            host_valid   = 1'b0;
            net_tx_ready = 1'b1;
            #1;
            check1($sformatf("timeout_err_c%0d", c), err, (c == TIMEOUT_CYC));
        end
        @(negedge clk);
        idle_inputs();
        #1;
        check1("timeout_busy", busy, 1'b0);
        check1("timeout_no_done", done, 1'b0);
        check1("timeout_err_pulse", err, 1'b0);

`ifdef ASP_CHECKSUM_EN
        // Test 5: RXA 1..4 with good and bad checksum
        for (int i = 0; i < BURST_LEN; i++) wbuf[i] = 32'(i + 1);
        corrupt_chk = 1'b0;
        run_rxa(1'b0, 1'b0);
        corrupt_chk = 1'b1;
        run_rxa(1'b0, 1'b0);
        corrupt_chk = 1'b0;
`endif

        // Test 6: reset during word 2 of TXE
        @(negedge clk);
        opcode = OP_TXE;
        @(negedge clk);
        opcode       = OP_NOP;
        host_valid   = 1'b1;
        net_tx_ready = 1'b1;
        host_data    = 32'd1;
        @(negedge clk);
        host_data = 32'd2;
        #1;
        check1("rst_mid_pre_valid", net_tx_valid, 1'b1);
        reset = 1'b1;
        exp_log = '0;
        #1;
        check1("rst_mid_tx_valid", net_tx_valid, 1'b0);
        check1("rst_mid_host_ready", host_ready, 1'b0);
        check32("rst_mid_tx_data", net_tx_data, '0);
        check1("rst_mid_busy", busy, 1'b0);
        check32("rst_mid_log", {16'h0, log_count}, {16'h0, exp_log});
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        for (int i = 0; i < BURST_LEN; i++) wbuf[i] = 32'(i + 1);
        run_txe(1'b0);

        // Randomized bursts and logs
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < BURST_LEN; i++) wbuf[i] = $urandom;
            case ($urandom_range(0, 2))
                0:       run_txe(1'b1);
                1:       run_rxa(1'b1, 1'b0);
                default: run_log();
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
